sound_rom_arbiter: RTL

//  Shares one synchronous delta-table ROM (sound_delta) among NUM_REQ rocket voices.

---
 rtl/sound_rom_arbiter_if.sv | 29 ++
 rtl/sound_rom_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sound_rom_arbiter_if.sv
// Purpose : request/grant/response bundle between rocket voices, the shared
//           delta-ROM arbiter and the ROM itself.
// Ports   : req/req_addr (voice -> arbiter), gnt/rsp_valid/rsp_data (arbiter -> voice),
//           rom_address (arbiter -> ROM), rom_q (ROM -> arbiter), busy (status).
// Modports: master = voices + ROM side, slave = arbiter.
interface sound_rom_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 9
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic                      busy;

  modport master (
    output req, req_addr, rom_q,
    input  gnt, rsp_valid, rsp_data, rom_address, busy
  );

  modport slave (
    input  req, req_addr, rom_q,
    output gnt, rsp_valid, rsp_data, rom_address, busy
  );
endinterface

// File: rtl/sound_rom_arbiter.sv
// Purpose : round-robin sharing of one synchronous delta ROM among NUM_REQ voices.
// Latency : gnt to rsp_valid = ROM_LAT+1 edges; one lookup per ROM_LAT+1 cycles.
// Backpr. : level req is held by the voice until gnt; requests are ignored while a lookup waits.
// Ports   : clk, reset (sync, active-high), bus (slave modport: req, req_addr, gnt,
//           rsp_valid, rsp_data, rom_address, rom_q, busy).
module sound_rom_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 9,
  parameter int ROM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  sound_rom_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ROM_LAT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  vld_q, vld_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                win_vld;
  logic [IDX_W-1:0]    win_idx;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic                capture;
  int                  cand;

  // Unpack the flat address bus into per-requester words.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Round-robin scan: start just after the last winner and wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = last_q;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!win_vld && bus.req[IDX_W'(cand)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    gnt_d   = '0;
    vld_d   = '0;
    data_d  = data_q;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        capture = win_vld;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // ROM word for the owner is on rom_q now; return it and, if anyone
          // is asking, start the next lookup on the same edge.
          data_d         = bus.rom_q;
          vld_d[owner_q] = 1'b1;
          if (win_vld) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      addr_d          = addr_arr[win_idx];
      gnt_d[win_idx]  = 1'b1;
      cnt_d           = CNT_W'(ROM_LAT);
      state_d         = WAIT;
      last_d          = win_idx;
      owner_d         = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      addr_q  <= '0;
      gnt_q   <= '0;
      vld_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rsp_valid   = vld_q;
  assign bus.rsp_data    = data_q;
  assign bus.rom_address = addr_q;
  assign bus.busy        = (state_q == WAIT);

endmodule
